// File: rtl/keypad_timer_loader_if.sv
// Keypad key handshake: strobe, code and acceptance between keypad and loader.
interface keypad_timer_loader_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_timer_loader.sv
// Keypad front end for the countdown timer: buffers digit keys in a FIFO,
// shifts each into the timer load chain with a one-cycle active-low load
// pulse, keeps a display shadow of the loaded digits and flags bad entries.
module keypad_timer_loader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned N_DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  clear,
  keypad_timer_loader_if.slave  key,
  input  logic                  timer_en,
  output logic                  load_n,
  output logic [3:0]            digit_out,
  output logic [3:0]            shadow_min,
  output logic [3:0]            shadow_tens,
  output logic [3:0]            shadow_units,
  output logic [1:0]            digits_entered,
  output logic                  entry_error,
  output logic                  busy
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned ZW = $clog2(2 * N_DIGITS);

  typedef enum logic [1:0] {IDLE, LOAD, GAP, ZERO} state_t;

  state_t        state, state_nx;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [ZW-1:0] zstep, zstep_nx;
  logic          fifo_full, fifo_empty;
  logic          accept, is_digit, clr_entry, illegal, push, pop, zero_last;
  logic [3:0]    head;

  logic          load_n_nx;
  logic [3:0]    digit_nx, min_nx, tens_nx, units_nx;
  logic [1:0]    de_nx;
  logic          err_nx;

  // Key acceptance and FIFO control decode
  always_comb begin
    fifo_full     = (count == (AW+1)'(FIFO_DEPTH));
    fifo_empty    = (count == '0);
    key.key_ready = !fifo_full && !timer_en && (state != ZERO);
    accept        = key.key_valid && key.key_ready;
    is_digit      = (key.key_code <= 4'd9);
    clr_entry     = accept && (key.key_code == 4'hC);
    illegal       = accept && !is_digit && (key.key_code != 4'hC);
    push          = accept && is_digit;
    // A clear-entry on the same edge wins over popping the head digit
    pop           = (state == IDLE) && !fifo_empty && !timer_en && !clr_entry;
    head          = mem[rd_ptr];
    zero_last     = (zstep == ZW'(2 * N_DIGITS - 1));
    busy          = !fifo_empty || (state != IDLE);
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= key.key_code;
  end

  // FIFO pointers and occupancy; clear-entry flushes
  always_ff @(posedge clk) begin
    if (clear || clr_entry) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (clear) begin
      state          <= IDLE;
      zstep          <= '0;
      load_n         <= 1'b1;
      digit_out      <= '0;
      shadow_min     <= '0;
      shadow_tens    <= '0;
      shadow_units   <= '0;
      digits_entered <= '0;
      entry_error    <= 1'b0;
    end else begin
      state          <= state_nx;
      zstep          <= zstep_nx;
      load_n         <= load_n_nx;
      digit_out      <= digit_nx;
      shadow_min     <= min_nx;
      shadow_tens    <= tens_nx;
      shadow_units   <= units_nx;
      digits_entered <= de_nx;
      entry_error    <= err_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (clr_entry) begin
      state_nx = ZERO;
    end else begin
      unique case (state)
        IDLE:    if (pop) state_nx = LOAD;
        LOAD:    state_nx = GAP;
        GAP:     state_nx = IDLE;
        ZERO:    if (zero_last) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs
  // ZERO stays one state for the whole sequence: even steps pulse load_n low
  // with a zero digit, odd steps are the gap, so key_ready holds low throughout.
  always_comb begin
    logic       shift;
    logic [3:0] shift_in;
    shift     = 1'b0;
    shift_in  = '0;
    load_n_nx = load_n;
    digit_nx  = digit_out;
    min_nx    = shadow_min;
    tens_nx   = shadow_tens;
    units_nx  = shadow_units;
    de_nx     = digits_entered;
    err_nx    = entry_error;
    zstep_nx  = zstep;
    unique case (state)
      IDLE: if (pop) begin
        load_n_nx = 1'b0;
        digit_nx  = head;
        shift     = 1'b1;
        shift_in  = head;
        if (digits_entered != 2'(N_DIGITS)) de_nx = digits_entered + 2'd1;
      end
      LOAD: load_n_nx = 1'b1;
      GAP:  ;
      ZERO: begin
        if (!zstep[0]) begin
          load_n_nx = 1'b0;
          digit_nx  = '0;
          shift     = 1'b1;
        end else begin
          load_n_nx = 1'b1;
        end
        zstep_nx = zstep + 1'b1;
        if (zero_last) begin
          zstep_nx = '0;
          de_nx    = '0;
        end
      end
      default: ;
    endcase
    if (shift) begin
      min_nx   = shadow_tens;
      tens_nx  = shadow_units;
      units_nx = shift_in;
      if (shadow_units > 4'd5) err_nx = 1'b1;
    end
    if (key.key_valid && !key.key_ready) err_nx = 1'b1;
    if (illegal) err_nx = 1'b1;
    if (clr_entry) begin
      err_nx    = 1'b0;
      load_n_nx = 1'b1;
      zstep_nx  = '0;
    end
  end
endmodule

// File: tb/tb_keypad_timer_loader.sv
// Bench for keypad_timer_loader: expected load digits are queued as keys are
// driven and popped by a monitor whenever a load pulse is observed.
module tb_keypad_timer_loader;
  logic       clk = 1'b0;
  logic       clear;
  logic       timer_en;
  logic       load_n;
  logic [3:0] digit_out, shadow_min, shadow_tens, shadow_units;
  logic [1:0] digits_entered;
  logic       entry_error, busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int loads_seen = 0;
  logic mon_en   = 1'b0;
  logic prev_load_n = 1'b1;
  logic [3:0] exp_q [$];
  int load_cyc [$];

  keypad_timer_loader_if key_if ();

  keypad_timer_loader #(.FIFO_DEPTH(4), .N_DIGITS(3)) dut (
    .clk(clk), .clear(clear), .key(key_if), .timer_en(timer_en),
    .load_n(load_n), .digit_out(digit_out), .shadow_min(shadow_min),
    .shadow_tens(shadow_tens), .shadow_units(shadow_units),
    .digits_entered(digits_entered), .entry_error(entry_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every low load_n sample must carry the next queued digit
  always @(negedge clk) begin : mon
    logic [3:0] e;
    if (mon_en && load_n === 1'b0) begin
      loads_seen++;
      load_cyc.push_back(cyc);
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL load_digit: unexpected load digit_out=%0d, none required", digit_out);
      end else begin
        e = exp_q.pop_front();
        if (digit_out !== e) begin
          mismatched++;
          $display("FAIL load_digit: digit_out=%0d required=%0d", digit_out, e);
        end
      end
      compared++;
      if (prev_load_n !== 1'b1) begin
        mismatched++;
        $display("FAIL load_width: load_n low for more than one cycle");
      end
    end
    prev_load_n = load_n;
  end

  task automatic send_key(input logic [3:0] code);
    @(negedge clk);
    key_if.key_valid = 1'b1;
    key_if.key_code  = code;
    @(negedge clk);
    key_if.key_valid = 1'b0;
  endtask

  task automatic test_reset;
    clear = 1'b1; timer_en = 1'b0;
    key_if.key_valid = 1'b0; key_if.key_code = '0;
    @(negedge clk); @(negedge clk);
    clear = 1'b0;
    mon_en = 1'b1;
    compared++; if (load_n !== 1'b1) begin mismatched++; $display("FAIL rst_load_n: got %b want 1", load_n); end
    compared++; if (digit_out !== 4'd0) begin mismatched++; $display("FAIL rst_digit: got %0d want 0", digit_out); end
    compared++; if (shadow_min !== 4'd0) begin mismatched++; $display("FAIL rst_min: got %0d want 0", shadow_min); end
    compared++; if (shadow_tens !== 4'd0) begin mismatched++; $display("FAIL rst_tens: got %0d want 0", shadow_tens); end
    compared++; if (shadow_units !== 4'd0) begin mismatched++; $display("FAIL rst_units: got %0d want 0", shadow_units); end
    compared++; if (digits_entered !== 2'd0) begin mismatched++; $display("FAIL rst_entered: got %0d want 0", digits_entered); end
    compared++; if (entry_error !== 1'b0) begin mismatched++; $display("FAIL rst_error: got %b want 0", entry_error); end
    compared++; if (key_if.key_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready: got %b want 1", key_if.key_ready); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_spaced;
    logic [3:0] k [3];
    k[0] = 4'd1; k[1] = 4'd3; k[2] = 4'd0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(k[i]);
      send_key(k[i]);
      compared++; if (load_n !== 1'b1) begin mismatched++; $display("FAIL spaced_early: load_n=%b want 1", load_n); end
      @(negedge clk);
      compared++; if (load_n !== 1'b0) begin mismatched++; $display("FAIL spaced_latency: load_n=%b want 0", load_n); end
      compared++; if (shadow_units !== k[i]) begin mismatched++; $display("FAIL spaced_units: got %0d want %0d", shadow_units, k[i]); end
      repeat (2) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("FAIL spaced_pending: %0d loads missing, want 0", exp_q.size()); end
    compared++; if ({shadow_min, shadow_tens, shadow_units} !== 12'h130) begin mismatched++; $display("FAIL spaced_shadow: got %h want 130", {shadow_min, shadow_tens, shadow_units}); end
    compared++; if (digits_entered !== 2'd3) begin mismatched++; $display("FAIL spaced_entered: got %0d want 3", digits_entered); end
    compared++; if (entry_error !== 1'b0) begin mismatched++; $display("FAIL spaced_error: got %b want 0", entry_error); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] k [4];
    k[0] = 4'd2; k[1] = 4'd5; k[2] = 4'd9; k[3] = 4'd4;
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    load_cyc.delete();
    key_if.key_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      compared++; if (key_if.key_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, key_if.key_ready); end
      key_if.key_code = k[i];
      exp_q.push_back(k[i]);
      @(negedge clk);
    end
    key_if.key_valid = 1'b0;
    repeat (14) @(negedge clk);
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("FAIL b2b_pending: %0d loads missing, want 0", exp_q.size()); end
    compared++; if (load_cyc.size() != 4) begin mismatched++; $display("FAIL b2b_loads: got %0d want 4", load_cyc.size()); end
    for (int i = 1; i < load_cyc.size(); i++) begin
      compared++;
      if (load_cyc[i] - load_cyc[i-1] != 3) begin mismatched++; $display("FAIL b2b_pitch[%0d]: got %0d want 3", i, load_cyc[i] - load_cyc[i-1]); end
    end
    compared++; if ({shadow_min, shadow_tens, shadow_units} !== 12'h594) begin mismatched++; $display("FAIL b2b_shadow: got %h want 594", {shadow_min, shadow_tens, shadow_units}); end
    compared++; if (entry_error !== 1'b1) begin mismatched++; $display("FAIL b2b_error: got %b want 1", entry_error); end
  endtask

  // Pops run at one per three cycles, so a continuous key stream fills the
  // 4-deep FIFO on the sixth key; keys 7 and 8 meet a full FIFO (8 also
  // coincides with a pop) and are dropped.
  task automatic test_fifo_full;
    logic rdy_exp [8];
    for (int i = 0; i < 8; i++) rdy_exp[i] = (i < 6);
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    key_if.key_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      compared++; if (key_if.key_ready !== rdy_exp[i]) begin mismatched++; $display("FAIL full_ready[%0d]: got %b want %b", i, key_if.key_ready, rdy_exp[i]); end
      key_if.key_code = 4'(i + 1);
      if (rdy_exp[i]) exp_q.push_back(4'(i + 1));
      @(negedge clk);
    end
    key_if.key_valid = 1'b0;
    repeat (20) @(negedge clk);
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("FAIL full_pending: %0d loads missing, want 0", exp_q.size()); end
    compared++; if ({shadow_min, shadow_tens, shadow_units} !== 12'h456) begin mismatched++; $display("FAIL full_shadow: got %h want 456", {shadow_min, shadow_tens, shadow_units}); end
    compared++; if (entry_error !== 1'b1) begin mismatched++; $display("FAIL full_error: got %b want 1", entry_error); end
  endtask

  task automatic test_clear_entry;
    int base;
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    send_key(4'hB);
    compared++; if (entry_error !== 1'b1) begin mismatched++; $display("FAIL ce_pre_error: got %b want 1", entry_error); end
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(4'(i));
      send_key(4'(i));
    end
    repeat (10) @(negedge clk);
    compared++; if ({shadow_min, shadow_tens, shadow_units} !== 12'h123) begin mismatched++; $display("FAIL ce_loaded: got %h want 123", {shadow_min, shadow_tens, shadow_units}); end
    base = loads_seen;
    for (int i = 0; i < 3; i++) exp_q.push_back(4'd0);
    send_key(4'hC);
    compared++; if (entry_error !== 1'b0) begin mismatched++; $display("FAIL ce_error: got %b want 0", entry_error); end
    for (int i = 0; i < 6; i++) begin
      compared++; if (key_if.key_ready !== 1'b0) begin mismatched++; $display("FAIL ce_ready[%0d]: got %b want 0", i, key_if.key_ready); end
      @(negedge clk);
    end
    compared++; if (key_if.key_ready !== 1'b1) begin mismatched++; $display("FAIL ce_ready_end: got %b want 1", key_if.key_ready); end
    compared++; if (loads_seen - base != 3) begin mismatched++; $display("FAIL ce_pulses: got %0d want 3", loads_seen - base); end
    compared++; if ({shadow_min, shadow_tens, shadow_units} !== 12'h000) begin mismatched++; $display("FAIL ce_shadow: got %h want 000", {shadow_min, shadow_tens, shadow_units}); end
    compared++; if (digits_entered !== 2'd0) begin mismatched++; $display("FAIL ce_entered: got %0d want 0", digits_entered); end
  endtask

  task automatic test_timer_en;
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    key_if.key_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      key_if.key_code = 4'(i);
      exp_q.push_back(4'(i));
      @(negedge clk);
    end
    key_if.key_valid = 1'b0;
    timer_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      compared++; if (load_n !== 1'b1) begin mismatched++; $display("FAIL ten_load[%0d]: load_n=%b want 1", i, load_n); end
      compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL ten_busy[%0d]: got %b want 1", i, busy); end
      compared++; if (key_if.key_ready !== 1'b0) begin mismatched++; $display("FAIL ten_ready[%0d]: got %b want 0", i, key_if.key_ready); end
    end
    compared++; if (exp_q.size() != 2) begin mismatched++; $display("FAIL ten_held: %0d loads pending, want 2", exp_q.size()); end
    timer_en = 1'b0;
    @(negedge clk);
    compared++; if (load_n !== 1'b0) begin mismatched++; $display("FAIL ten_resume: load_n=%b want 0", load_n); end
    repeat (8) @(negedge clk);
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("FAIL ten_pending: %0d loads missing, want 0", exp_q.size()); end
    compared++; if ({shadow_min, shadow_tens, shadow_units} !== 12'h123) begin mismatched++; $display("FAIL ten_shadow: got %h want 123", {shadow_min, shadow_tens, shadow_units}); end
  endtask

  task automatic test_illegal_and_clear;
    int base;
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    base = loads_seen;
    send_key(4'hB);
    compared++; if (entry_error !== 1'b1) begin mismatched++; $display("FAIL ill_error: got %b want 1", entry_error); end
    repeat (4) @(negedge clk);
    compared++; if (loads_seen != base) begin mismatched++; $display("FAIL ill_load: got %0d loads want 0", loads_seen - base); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL ill_busy: got %b want 0", busy); end
    exp_q.push_back(4'd8);
    send_key(4'd8);
    @(negedge clk);
    compared++; if (load_n !== 1'b0) begin mismatched++; $display("FAIL mid_load: load_n=%b want 0", load_n); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    compared++; if (load_n !== 1'b1) begin mismatched++; $display("FAIL clr_load_n: got %b want 1", load_n); end
    compared++; if (digit_out !== 4'd0) begin mismatched++; $display("FAIL clr_digit: got %0d want 0", digit_out); end
    compared++; if ({shadow_min, shadow_tens, shadow_units} !== 12'h000) begin mismatched++; $display("FAIL clr_shadow: got %h want 000", {shadow_min, shadow_tens, shadow_units}); end
    compared++; if (digits_entered !== 2'd0) begin mismatched++; $display("FAIL clr_entered: got %0d want 0", digits_entered); end
    compared++; if (entry_error !== 1'b0) begin mismatched++; $display("FAIL clr_error: got %b want 0", entry_error); end
    compared++; if (key_if.key_ready !== 1'b1) begin mismatched++; $display("FAIL clr_ready: got %b want 1", key_if.key_ready); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL clr_busy: got %b want 0", busy); end
    compared++; if (exp_q.size() != 0) begin mismatched++; $display("FAIL clr_pending: %0d loads missing, want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_spaced();
    test_back_to_back();
    test_fifo_full();
    test_clear_entry();
    test_timer_en();
    test_illegal_and_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end
endmodule
